// File: rtl/datapath_arbiter.sv
// datapath_arbiter: two-requester round-robin front end for the shared arithmetic datapath.
// Build option DPCTL_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties). Rev 1.0
`default_nettype none

module datapath #(
  parameter int N = 16
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [2:0]   opcode,
  output logic [N-1:0] Y,
  output logic         co
);
  always_comb begin
    Y  = '0;
    co = 1'b0;
    case (opcode)
      3'b000: {co, Y} = {1'b0, A} + {1'b0, B};
      3'b001: {co, Y} = {1'b0, A} - {1'b0, B};  // co is the borrow
      3'b010: Y = A & B;
      3'b011: Y = A | B;
      3'b100: Y = A ^ B;
      3'b101: begin
        Y  = A << 1;
        co = A[N-1];
      end
      3'b110: begin
        Y  = {A[N-1], A[N-1:1]};
        co = A[0];
      end
      default: begin
        Y  = '0;
        co = 1'b0;
      end
    endcase
  end
endmodule

module datapath_arbiter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_y,
  output logic         rsp_co,
  output logic         rsp_id
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [N-1:0] a_q, b_q;
  logic [2:0]  op_q;
  logic        last_grant;
  logic        tie_to_0;
  logic        grant0, grant1;
  logic [N-1:0] dp_y;
  logic        dp_co;

  always_comb begin
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
`ifdef DPCTL_FIXED_PRIO_EN
    // last_grant keeps being tracked but never changes the tie outcome
    tie_to_0   = last_grant | 1'b1;
`else
    tie_to_0   = last_grant;
`endif
    case (state)
      IDLE: begin
        if (rst_n) begin
          grant0 = req0_valid & (~req1_valid | tie_to_0);
          grant1 = req1_valid & ~grant0;
        end
        if (grant0 | grant1) state_next = EXEC;
      end
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = (state == RESP);

  datapath #(.N(N)) u_datapath (
    .A      (a_q),
    .B      (b_q),
    .opcode (op_q),
    .Y      (dp_y),
    .co     (dp_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      last_grant <= 1'b1;
      rsp_y      <= '0;
      rsp_co     <= 1'b0;
      rsp_id     <= 1'b0;
    end else begin
      state <= state_next;
      if (grant0 | grant1) begin
        a_q        <= grant1 ? req1_a  : req0_a;
        b_q        <= grant1 ? req1_b  : req0_b;
        op_q       <= grant1 ? req1_op : req0_op;
        rsp_id     <= grant1;
        last_grant <= grant1;
      end
      if (state == EXEC) begin
        rsp_y  <= dp_y;
        rsp_co <= dp_co;
      end
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_datapath_arbiter.sv
// Self-checking bench for datapath_arbiter: transaction-level model plus directed literal checks.
`default_nettype none

module tb_datapath_arbiter;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]   req0_op = '0, req1_op = '0;
  logic         rsp_valid, rsp_co, rsp_id;
  logic         rsp_ready = 1'b1;
  logic [N-1:0] rsp_y;

  logic [N-1:0] ref_a = '0, ref_b = '0;
  logic [2:0]   ref_op = '0;
  logic [N-1:0] ref_y;
  logic         ref_co;

  datapath_arbiter #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_co(rsp_co), .rsp_id(rsp_id)
  );

  datapath #(.N(N)) ref_dp (.A(ref_a), .B(ref_b), .opcode(ref_op), .Y(ref_y), .co(ref_co));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Arithmetic meaning of each opcode, computed with plain integers
  function automatic logic [N:0] dp_model(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
    int unsigned ua, ub, s;
    logic [N-1:0] y;
    logic co;
    ua = a; ub = b; y = '0; co = 1'b0;
    case (op)
      3'd0: begin s = ua + ub; y = s[N-1:0]; co = (s >= (1 << N)); end
      3'd1: begin s = ua - ub; y = s[N-1:0]; co = (ua < ub); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: begin s = ua * 2; y = s[N-1:0]; co = a[N-1]; end
      3'd6: begin s = ua / 2; y = s[N-1:0]; y[N-1] = a[N-1]; co = a[0]; end
      default: begin y = '0; co = 1'b0; end
    endcase
    return {co, y};
  endfunction

  typedef struct {
    logic [N-1:0] y;
    logic         co;
    logic         id;
    int           acc;
  } txn_t;

  txn_t q[$];
  logic m_last = 1'b1;
  int   lg_n = 0;
  logic lg_id[64];
  logic [N-1:0] lg_y[64];
  logic lg_co[64];
  int   lg_lat[64];

  // Compare process: one transaction in flight at most, response due two cycles after accept
  always @(negedge clk) begin
    logic busy, e0, e1, ev, fixed;
    logic [N:0] r;
    txn_t t;
`ifdef DPCTL_FIXED_PRIO_EN
    fixed = 1'b1;
`else
    fixed = 1'b0;
`endif
    if (!rst_n) begin
      q.delete();
      m_last = 1'b1;
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_y", rsp_y, 0);
      chk("rst_rsp_co", rsp_co, 0);
      chk("rst_rsp_id", rsp_id, 0);
    end else begin
      busy = (q.size() != 0);
      e0 = !busy && req0_valid && (!req1_valid || fixed || m_last);
      e1 = !busy && req1_valid && !e0;
      ev = 1'b0;
      if (busy) ev = (cyc >= q[0].acc + 2);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
        chk("rsp_y", rsp_y, q[0].y);
        chk("rsp_co", rsp_co, q[0].co);
        chk("rsp_id", rsp_id, q[0].id);
      end
      if (e0 || e1) begin
        r = e1 ? dp_model(req1_a, req1_b, req1_op) : dp_model(req0_a, req0_b, req0_op);
        t.y = r[N-1:0]; t.co = r[N]; t.id = e1; t.acc = cyc;
        q.push_back(t);
        m_last = e1;
      end
      if (ev && rsp_ready) begin
        lg_id[lg_n] = rsp_id; lg_y[lg_n] = rsp_y; lg_co[lg_n] = rsp_co;
        lg_lat[lg_n] = cyc - q[0].acc;
        lg_n++;
        void'(q.pop_front());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_grant(input string name);
    int i;
    for (i = 0; i < 50; i++) begin
      #1;
      if (req0_ready || req1_ready) break;
      @(posedge clk);
      #1;
    end
    chk(name, (i < 50), 1);
    step(1);
  endtask

  task automatic wait_resp(input string name, input int target);
    int i;
    for (i = 0; i < 100 && lg_n < target; i++) step(1);
    chk(name, (lg_n >= target), 1);
  endtask

  initial begin
    int b;
    int i;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    int i;
    step(3);
    chk("reset_rsp_valid", rsp_valid, 0);
    rst_n = 1'b1;
    step(1);

    // Tie: both requesters valid continuously
    b = lg_n;
    req0_a = 16'd1; req0_b = 16'd1; req0_op = 3'b000;
    req1_a = 16'd100; req1_b = 16'hFFFD; req1_op = 3'b000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_resp("tie_timeout", b + 4);
    req0_valid = 1'b0; req1_valid = 1'b0;
`ifdef DPCTL_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) begin
      chk("tie_id_fixed", lg_id[b+k], 0);
      chk("tie_y_fixed", lg_y[b+k], 16'd2);
    end
`else
    for (int k = 0; k < 4; k++) begin
      chk("tie_id_rr", lg_id[b+k], k % 2);
      chk("tie_y_rr", lg_y[b+k], (k % 2) ? 16'd97 : 16'd2);
    end
    chk("tie_co_req1", lg_co[b+1], 1);
`endif
    step(2);

    // Single request: 5 + 7
    b = lg_n;
    req0_a = 16'd5; req0_b = 16'd7; req0_op = 3'b000; req0_valid = 1'b1;
    wait_grant("single_grant");
    req0_valid = 1'b0;
    wait_resp("single_timeout", b + 1);
    chk("single_y", lg_y[b], 16'd12);
    chk("single_co", lg_co[b], 0);
    chk("single_id", lg_id[b], 0);
    chk("single_latency", lg_lat[b], 2);

    // Backpressure: hold response 5 cycles while req1 waits
    step(1);
    b = lg_n;
    rsp_ready = 1'b0;
    req0_a = 16'd3; req0_b = 16'd5; req0_op = 3'b001; req0_valid = 1'b1;
    wait_grant("bp_grant0");
    req0_valid = 1'b0;
    req1_a = 16'd9; req1_b = 16'd4; req1_op = 3'b111; req1_valid = 1'b1;
    for (i = 0; i < 20 && !rsp_valid; i++) step(1);
    chk("bp_valid_seen", rsp_valid, 1);
    step(5);
    chk("bp_still_valid", rsp_valid, 1);
    chk("bp_no_handshake", lg_n, b);
    rsp_ready = 1'b1;
    wait_grant("bp_grant1");
    req1_valid = 1'b0;
    wait_resp("bp_timeout", b + 2);
    chk("bp_sub_y", lg_y[b], 16'hFFFE);
    chk("bp_sub_co", lg_co[b], 1);
    chk("bp_op7_id", lg_id[b+1], 1);
    chk("bp_op7_y", lg_y[b+1], 16'h0000);

    // Overflow passthrough, also against a standalone datapath
    step(1);
    b = lg_n;
    req0_a = 16'h7FFF; req0_b = 16'h0001; req0_op = 3'b000; req0_valid = 1'b1;
    ref_a = 16'h7FFF; ref_b = 16'h0001; ref_op = 3'b000;
    wait_grant("ovf_grant");
    req0_valid = 1'b0;
    wait_resp("ovf_timeout", b + 1);
    chk("ovf_y", lg_y[b], 16'h8000);
    chk("ovf_co", lg_co[b], 0);
    chk("ovf_y_vs_ref", lg_y[b], ref_y);
    chk("ovf_co_vs_ref", lg_co[b], ref_co);

    // Reset in EXEC aborts the transaction
    step(1);
    req0_a = 16'd2; req0_b = 16'd3; req0_op = 3'b000; req0_valid = 1'b1;
    wait_grant("rst_grant");
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rsp_valid", rsp_valid, 0);
    chk("async_rsp_y", rsp_y, 0);
    chk("async_req0_ready", req0_ready, 0);
    step(2);
    rst_n = 1'b1;
    b = lg_n;
    step(5);
    chk("no_stale_rsp", lg_n, b);
    req0_a = 16'd1; req0_b = 16'd1; req0_op = 3'b000;
    req1_a = 16'd100; req1_b = 16'hFFFD; req1_op = 3'b000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_grant("post_rst_grant");
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp("post_rst_timeout", b + 1);
    chk("post_rst_tie_id", lg_id[b], 0);
    chk("post_rst_tie_y", lg_y[b], 16'd2);
    step(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
